uart_regif: RTL and testbench

Bus-responder register interface that sits between a UART core's byte-level RX/TX ports and a polling bus master using the adrs/CSn/OE/WE strobe bus. It exposes a status register (adrs=1) and a data register (adrs=0). It buffers received bytes, holds one byte for transmission, and records sticky error flags that a status read clears.

---
 rtl/uart_regif_pkg.sv | 36 +++
 rtl/uart_regif_if.sv | 15 +
 rtl/uart_regif_rxbuf.sv | 98 +++++++++
 rtl/uart_regif.sv | 119 +++++++++++
 tb/tb_uart_regif.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_regif_pkg.sv
// Purpose: shared constants, types and status packing for the uart_regif register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register addresses, status bit positions, status reset value, sticky flag struct.
package uart_regif_pkg;

  localparam logic ADDR_STATUS = 1'b1;
  localparam logic ADDR_DATA   = 1'b0;

  localparam int ST_PARITY   = 5;
  localparam int ST_OVERFLOW = 4;
  localparam int ST_TXOVR    = 2;
  localparam int ST_TXRDY    = 1;
  localparam int ST_RXRDY    = 0;

  localparam logic [7:0] STATUS_RESET = 8'h02;

  // Error flags that stay set until a status read clears them.
  typedef struct packed {
    logic parity_err;
    logic rx_overflow;
    logic tx_overrun;
  } sticky_t;

  function automatic logic [7:0] pack_status(sticky_t s, logic tx_rdy, logic rx_rdy);
    logic [7:0] st;
    st              = '0;
    st[ST_PARITY]   = s.parity_err;
    st[ST_OVERFLOW] = s.rx_overflow;
    st[ST_TXOVR]    = s.tx_overrun;
    st[ST_TXRDY]    = tx_rdy;
    st[ST_RXRDY]    = rx_rdy;
    return st;
  endfunction

endpackage

// File: rtl/uart_regif_if.sv
// Purpose: strobe-bus bundle between a polling master and the uart_regif responder.
// Latency: n/a (wires only); read data is combinational in the responder.
// Backpressure: none; the master polls status before accessing data.
// Signals: adrs, CSn, OE, WE, bus_wdata (master -> responder), bus_rdata (responder -> master).
interface uart_regif_if;
  logic       adrs;
  logic       CSn;
  logic       OE;
  logic       WE;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  modport master (output adrs, CSn, OE, WE, bus_wdata, input bus_rdata);
  modport slave  (input adrs, CSn, OE, WE, bus_wdata, output bus_rdata);
endinterface

// File: rtl/uart_regif_rxbuf.sv
// Purpose: RX byte buffer; RX_FIFO_EN selects an RX_DEPTH-entry circular FIFO, else a single holding register.
// Latency: push visible at dout/empty the cycle after the push edge; pop advances head the next cycle.
// Backpressure: push while full is dropped unless a pop happens on the same edge; pop while empty is ignored.
// Ports: clk, reset_ns, push/din (write side), pop/dout (read side, dout = head), empty, full.
module uart_regif_rxbuf #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_ns,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  logic pop_ok;
  logic push_ok;

  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot, so a full buffer still accepts the push.
  assign push_ok = push && (!full || pop_ok);

`ifdef RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [RX_DEPTH];
  logic [7:0]    mem_d [RX_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  // Extra pointer MSB acts as a lap bit: equal low bits with differing MSBs means full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = din;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_ns) begin
    if (!reset_ns) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  assign empty = !full_q;
  assign full  = full_q;
  assign dout  = hold_q;

  // Depth is fixed at one entry here; RX_DEPTH has no effect in this build.
  if (RX_DEPTH < 1) begin : g_depth_ignored
  end

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (pop_ok) begin
      full_d = 1'b0;
    end
    if (push_ok) begin
      hold_d = din;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_ns) begin
    if (!reset_ns) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
`endif

endmodule

// File: rtl/uart_regif.sv
// Purpose: strobe-bus register block (status @1, data @0) in front of a UART core's RX/TX byte ports.
// Latency: 0-cycle read data; side effects (pop, status clear, TX load) take effect the cycle after the strobe edge.
// Backpressure: TX holds one byte (write while busy -> dropped + tx_overrun); RX full drops new bytes + rx_overflow.
// Ports: clk, reset_ns, bus (uart_regif_if.slave), rx_byte/rx_valid/rx_parity_err, tx_byte/tx_valid/tx_ready.
// Build option RX_FIFO_EN: RX buffer becomes an RX_DEPTH-entry FIFO instead of a single register.
module uart_regif
  import uart_regif_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_ns,
  uart_regif_if.slave bus,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_parity_err,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       rd_fire, wr_fire;
  logic       pop, st_clr;
  logic       rx_empty, rx_full;
  logic [7:0] rx_dout;
  sticky_t    sticky_q, sticky_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] status;

  // Strobes and their first-cycle edges; a held strobe fires only once.
  // OE has priority, so WE with OE is a plain read.
  always_comb begin
    rd_d    = !bus.CSn && bus.OE;
    wr_d    = !bus.CSn && bus.WE && !bus.OE && (bus.adrs == ADDR_DATA);
    rd_fire = rd_d && !rd_q;
    wr_fire = wr_d && !wr_q;
    pop     = rd_fire && (bus.adrs == ADDR_DATA) && !rx_empty;
    st_clr  = rd_fire && (bus.adrs == ADDR_STATUS);
  end

  uart_regif_rxbuf #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rxbuf (
    .clk      (clk),
    .reset_ns (reset_ns),
    .push     (rx_valid),
    .pop      (pop),
    .din      (rx_byte),
    .dout     (rx_dout),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  // Clear first, then sets, so an error arriving on the clearing edge survives.
  always_comb begin
    sticky_d = sticky_q;
    if (st_clr) begin
      sticky_d = '0;
    end
    if (rx_valid && rx_parity_err) begin
      sticky_d.parity_err = 1'b1;
    end
    if (rx_valid && rx_full && !pop) begin
      sticky_d.rx_overflow = 1'b1;
    end
    // TXrdy is judged on the registered tx_valid, so a write on a transfer edge still overruns.
    if (wr_fire && tx_valid_q) begin
      sticky_d.tx_overrun = 1'b1;
    end
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (wr_fire && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_byte_d  = bus.bus_wdata;
    end
  end

  assign status = pack_status(sticky_q, !tx_valid_q, !rx_empty);

  always_comb begin
    bus.bus_rdata = 8'h00;
    if (rd_d) begin
      if (bus.adrs == ADDR_STATUS) begin
        bus.bus_rdata = status;
      end else if (!rx_empty) begin
        bus.bus_rdata = rx_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ns) begin
    if (!reset_ns) begin
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      sticky_q   <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      sticky_q   <= sticky_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_regif.sv
// Purpose: self-checking bench for uart_regif: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_regif;
  import uart_regif_pkg::*;

  localparam int DEPTH = 4;
`ifdef RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_ns;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_parity_err;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  uart_regif_if bus ();

  uart_regif #(.RX_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_ns      (reset_ns),
    .bus           (bus),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: RX contents as a bounded queue, sticky flags as plain bits.
  logic [7:0] mq[$];
  bit         m_par, m_ovf, m_ovr, m_txv, m_rdq, m_wrq;
  logic [7:0] m_txb;

  task automatic m_reset();
    mq.delete();
    m_par = 0; m_ovf = 0; m_ovr = 0; m_txv = 0; m_rdq = 0; m_wrq = 0;
    m_txb = 8'h00;
  endtask

  function automatic logic [7:0] m_status();
    return {2'b00, m_par, m_ovf, 1'b0, m_ovr, !m_txv, (mq.size() != 0)};
  endfunction

  function automatic logic [7:0] m_rdata();
    if (!bus.CSn && bus.OE) begin
      if (bus.adrs == ADDR_STATUS) return m_status();
      if (mq.size() != 0) return mq[0];
    end
    return 8'h00;
  endfunction

  // Apply the effects of the coming clock edge to the model, then advance to just after that edge.
  task automatic tick();
    bit rd, wr, rd_e, wr_e, pop, txfer;
    rd    = !bus.CSn && bus.OE;
    wr    = !bus.CSn && bus.WE && !bus.OE && (bus.adrs == ADDR_DATA);
    rd_e  = rd && !m_rdq;
    wr_e  = wr && !m_wrq;
    pop   = rd_e && (bus.adrs == ADDR_DATA) && (mq.size() != 0);
    txfer = m_txv && tx_ready;
    if (rd_e && bus.adrs == ADDR_STATUS) begin m_par = 0; m_ovf = 0; m_ovr = 0; end
    if (rx_valid && rx_parity_err) m_par = 1;
    if (pop) void'(mq.pop_front());
    if (rx_valid) begin
      if (mq.size() < CAP) mq.push_back(rx_byte);
      else m_ovf = 1;
    end
    if (wr_e && m_txv) m_ovr = 1;
    if (txfer) m_txv = 0;
    if (wr_e && !m_txv && !txfer) begin m_txv = 1; m_txb = bus.bus_wdata; end
    m_rdq = rd;
    m_wrq = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic csn, input logic oe, input logic we, input logic a, input logic [7:0] wd);
    bus.CSn = csn; bus.OE = oe; bus.WE = we; bus.adrs = a; bus.bus_wdata = wd;
    #1;
  endtask

  task automatic idle();
    rx_valid = 1'b0; rx_parity_err = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_read(input logic a, output logic [7:0] v, output logic [7:0] e);
    drv(1'b0, 1'b1, 1'b0, a, 8'h00);
    v = bus.bus_rdata;
    e = m_rdata();
    tick();
    idle();
    tick();
  endtask

  task automatic do_write(input logic [7:0] d);
    drv(1'b0, 1'b0, 1'b1, ADDR_DATA, d);
    tick();
    idle();
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic p);
    rx_byte = b; rx_parity_err = p; rx_valid = 1'b1;
    #1;
    tick();
    rx_valid = 1'b0; rx_parity_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v, e;
    reset_ns = 1'b0; tx_ready = 1'b0; rx_byte = 8'h00;
    idle();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.bus_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.bus_rdata); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h exp 00", tx_byte); end
    @(negedge clk) reset_ns = 1'b1;
    @(posedge clk);
    #1;
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== STATUS_RESET) begin errors++; $display("FAIL reset_status got %h exp %h", v, STATUS_RESET); end
    do_read(ADDR_DATA, v, e);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL empty_data_read got %h exp 00", v); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL empty_read_no_effect got %h exp 02", v); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] v, e;
    push_byte(8'hA5, 1'b0);
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL rx_status got %h exp 03", v); end
    do_read(ADDR_DATA, v, e);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL rx_data got %h exp a5", v); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL rx_status_after got %h exp 02", v); end
  endtask

  task automatic test_overflow();
    logic [7:0] v, e;
    for (int i = 1; i <= 5; i++) push_byte(8'(i * 8'h11), 1'b0);
    idle();
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h13) begin errors++; $display("FAIL ovf_status got %h exp 13", v); end
    for (int i = 1; i <= CAP; i++) begin
      do_read(ADDR_DATA, v, e);
      checks++; if (v !== 8'(i * 8'h11)) begin errors++; $display("FAIL ovf_data%0d got %h exp %h", i, v, 8'(i * 8'h11)); end
    end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL ovf_drained got %h exp 02", v); end
  endtask

  task automatic test_parity();
    logic [7:0] v, e;
    push_byte(8'h7E, 1'b1);
    idle();
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h23) begin errors++; $display("FAIL par_status got %h exp 23", v); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL par_cleared got %h exp 03", v); end
    do_read(ADDR_DATA, v, e);
    checks++; if (v !== 8'h7E) begin errors++; $display("FAIL par_data got %h exp 7e", v); end
  endtask

  task automatic test_tx();
    logic [7:0] v, e;
    tx_ready = 1'b0;
    do_write(8'h3C);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_set got %b exp 1", tx_valid); end
    checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL tx_byte got %h exp 3c", tx_byte); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL tx_busy_status got %h exp 00", v); end
    do_write(8'h99);
    checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL tx_drop_byte got %h exp 3c", tx_byte); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL tx_overrun got %h exp 04", v); end
    do_write(8'hAA);
    tx_ready = 1'b1;
    #1;
    tick();
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drop_valid got %b exp 0", tx_valid); end
    checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL tx_hold_byte got %h exp 3c", tx_byte); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h06) begin errors++; $display("FAIL tx_done_status got %h exp 06", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, e;
    // Read then write with no idle cycle between.
    push_byte(8'h5A, 1'b0);
    drv(1'b0, 1'b1, 1'b0, ADDR_DATA, 8'h00);
    v = bus.bus_rdata;
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL b2b_read got %h exp 5a", v); end
    tick();
    drv(1'b0, 1'b0, 1'b1, ADDR_DATA, 8'h77);
    tick();
    idle();
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h77) begin errors++; $display("FAIL b2b_write got %b/%h exp 1/77", tx_valid, tx_byte); end
    // Write on the same edge as a TX transfer: dropped with overrun.
    tx_ready = 1'b1;
    drv(1'b0, 1'b0, 1'b1, ADDR_DATA, 8'hE1);
    tick();
    tx_ready = 1'b0;
    idle();
    tick();
    checks++; if (tx_valid !== 1'b0 || tx_byte !== 8'h77) begin errors++; $display("FAIL xfer_write got %b/%h exp 0/77", tx_valid, tx_byte); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h06) begin errors++; $display("FAIL xfer_write_status got %h exp 06", v); end
    // WE together with OE is a read only.
    push_byte(8'hC3, 1'b0);
    drv(1'b0, 1'b1, 1'b1, ADDR_DATA, 8'h12);
    v = bus.bus_rdata;
    checks++; if (v !== 8'hC3) begin errors++; $display("FAIL we_oe_read got %h exp c3", v); end
    tick();
    idle();
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL we_oe_nowrite got %b exp 0", tx_valid); end
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL we_oe_status got %h exp 02", v); end
  endtask

  task automatic test_oe_hold();
    logic [7:0] v, e;
    push_byte(8'hB1, 1'b0);
    push_byte(8'hB2, 1'b0);
    idle();
    do_read(ADDR_STATUS, v, e);
    drv(1'b0, 1'b1, 1'b0, ADDR_DATA, 8'h00);
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.bus_rdata !== m_rdata()) begin errors++; $display("FAIL hold_rd%0d got %h exp %h", c, bus.bus_rdata, m_rdata()); end
      tick();
    end
    idle();
    tick();
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== e || v !== {7'h01, (CAP > 1)}) begin errors++; $display("FAIL hold_one_pop got %h exp %h", v, e); end
    while (mq.size() != 0) do_read(ADDR_DATA, v, e);
    // Full buffer, held read, and a push on the pop edge.
    for (int i = 0; i < CAP; i++) push_byte(8'hC0 + 8'(i), 1'b0);
    rx_byte = 8'hEE; rx_valid = 1'b1;
    drv(1'b0, 1'b1, 1'b0, ADDR_DATA, 8'h00);
    tick();
    rx_valid = 1'b0;
    #1;
    tick();
    tick();
    idle();
    tick();
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL full_pop_push got %h exp 03", v); end
    for (int i = 0; i < CAP; i++) begin
      do_read(ADDR_DATA, v, e);
      checks++; if (v !== e) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, v, e); end
    end
    checks++; if (v !== 8'hEE) begin errors++; $display("FAIL full_last got %h exp ee", v); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v, e;
    push_byte(8'h61, 1'b1);
    do_write(8'h62);
    #2 reset_ns = 1'b0;
    #1;
    m_reset();
    checks++; if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin errors++; $display("FAIL arst_tx got %b/%h exp 0/00", tx_valid, tx_byte); end
    @(negedge clk) reset_ns = 1'b1;
    @(posedge clk);
    #1;
    do_read(ADDR_STATUS, v, e);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL arst_status got %h exp 02", v); end
    do_read(ADDR_DATA, v, e);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL arst_data got %h exp 00", v); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      rx_valid      = ($urandom_range(0, 3) == 0);
      rx_byte       = 8'($urandom);
      rx_parity_err = ($urandom_range(0, 7) == 0);
      tx_ready      = ($urandom_range(0, 2) == 0);
      drv(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      checks++; if (bus.bus_rdata !== m_rdata()) begin errors++; $display("FAIL rnd_rdata n=%0d got %h exp %h", n, bus.bus_rdata, m_rdata()); end
      checks++; if (tx_valid !== m_txv) begin errors++; $display("FAIL rnd_tx_valid n=%0d got %b exp %b", n, tx_valid, m_txv); end
      checks++; if (tx_byte !== m_txb) begin errors++; $display("FAIL rnd_tx_byte n=%0d got %h exp %h", n, tx_byte, m_txb); end
      tick();
    end
    idle();
    tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_overflow();
    test_parity();
    test_tx();
    test_back_to_back();
    test_oe_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
